// File: rtl/decodificador_teclado.sv
// BCD digit -> timed one-hot keypad press (hold, then release gap), valid/ready input.
// Optional macro DECOD_ERRO_EN adds the erro port, pulsed for one cycle when a code 10..15 is accepted.
module decodificador_teclado #(
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enablen,
    input  logic [3:0] BCD,
    input  logic       valido,
    output logic       pronto,
    output logic [9:0] keypad,
    output logic       ocupado
`ifdef DECOD_ERRO_EN
    ,
    output logic       erro
`endif
);

    typedef enum logic [1:0] {OCIOSO, PRESSIONA, SOLTA} estado_t;

    estado_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [9:0]       keypad_q;
    logic             pronto_q;
    logic             ocupado_q;
`ifdef DECOD_ERRO_EN
    logic             erro_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= OCIOSO;
            cnt_q     <= '0;
            keypad_q  <= '0;
            pronto_q  <= 1'b1;
            ocupado_q <= 1'b0;
`ifdef DECOD_ERRO_EN
            erro_q    <= 1'b0;
`endif
        end else begin
`ifdef DECOD_ERRO_EN
            erro_q <= 1'b0;
`endif
            case (state_q)
                OCIOSO: begin
                    // Codes 10..15 are consumed with the same handshake but never pressed.
                    if (valido && !enablen) begin
                        if (BCD <= 4'd9) begin
                            state_q   <= PRESSIONA;
                            keypad_q  <= 10'(1) << BCD;
                            cnt_q     <= CNT_W'(PRESS_CYCLES - 1);
                            pronto_q  <= 1'b0;
                            ocupado_q <= 1'b1;
                        end else begin
`ifdef DECOD_ERRO_EN
                            erro_q <= 1'b1;
`endif
                        end
                    end
                end
                PRESSIONA: begin
                    if (cnt_q == '0) begin
                        state_q  <= SOLTA;
                        keypad_q <= '0;
                        cnt_q    <= CNT_W'(GAP_CYCLES - 1);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SOLTA: begin
                    if (cnt_q == '0) begin
                        state_q   <= OCIOSO;
                        pronto_q  <= 1'b1;
                        ocupado_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= OCIOSO;
                    keypad_q  <= '0;
                    pronto_q  <= 1'b1;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign keypad  = keypad_q;
    assign pronto  = pronto_q;
    assign ocupado = ocupado_q;
`ifdef DECOD_ERRO_EN
    assign erro    = erro_q;
`endif

endmodule

// File: tb/tb_decodificador_teclado.sv
// Scoreboard bench: two decoders (4/2 and 1/1 timing) share one randomized stimulus stream;
// each has its own busy-countdown reference model and a queue of expected digits.
module tb_decodificador_teclado;

    localparam int P0 = 4, G0 = 2, P1 = 1, G1 = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enablen = 1'b0;
    logic [3:0] BCD = 4'd0;
    logic       valido = 1'b0;

    logic       pr [2];
    logic       oc [2];
    logic [9:0] kp [2];
    logic       er [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    decodificador_teclado #(.PRESS_CYCLES(P0), .GAP_CYCLES(G0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .enablen(enablen), .BCD(BCD), .valido(valido),
        .pronto(pr[0]), .keypad(kp[0]), .ocupado(oc[0])
`ifdef DECOD_ERRO_EN
        , .erro(er[0])
`endif
    );

    decodificador_teclado #(.PRESS_CYCLES(P1), .GAP_CYCLES(G1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .enablen(enablen), .BCD(BCD), .valido(valido),
        .pronto(pr[1]), .keypad(kp[1]), .ocupado(oc[1])
`ifdef DECOD_ERRO_EN
        , .erro(er[1])
`endif
    );

`ifndef DECOD_ERRO_EN
    assign er[0] = 1'b0;
    assign er[1] = 1'b0;
`endif

    function automatic int pc(input int i); return (i == 0) ? P0 : P1; endfunction
    function automatic int gc(input int i); return (i == 0) ? G0 : G1; endfunction

    function automatic void chk(input bit ok, input string nm, input int i, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h, want 0x%0h", nm, i, cyc, act, exp);
        end
    endfunction

    // Reference model: a digit occupies the block for PRESS+GAP cycles after accept,
    // the key is visible while more than GAP cycles of that busy time remain.
    int       m_left [2] = '{0, 0};
    int       m_dig  [2] = '{0, 0};
    bit       m_err  [2] = '{0, 0};
    int       q0 [$];
    int       q1 [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            m_err[i] <= 1'b0;
            if (reset) begin
                m_left[i] <= 0;
            end else if (m_left[i] > 0) begin
                m_left[i] <= m_left[i] - 1;
            end else if (valido && !enablen) begin
                if (BCD <= 4'd9) begin
                    m_left[i] <= pc(i) + gc(i);
                    m_dig[i]  <= int'(BCD);
                    if (i == 0) q0.push_back(int'(BCD));
                    else        q1.push_back(int'(BCD));
                end else begin
`ifdef DECOD_ERRO_EN
                    m_err[i] <= 1'b1;
`endif
                end
            end
        end
    end

    // Monitor: per-cycle output check plus scoreboard pop on every new key press.
    logic [9:0] prev_kp [2] = '{10'd0, 10'd0};

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                logic [9:0] ek;
                int         d;
                ek = (m_left[i] > gc(i)) ? (10'(1) << m_dig[i]) : 10'd0;
                chk(kp[i] === ek, "keypad", i, int'(kp[i]), int'(ek));
                chk(pr[i] === (m_left[i] == 0), "pronto", i, int'(pr[i]), int'(m_left[i] == 0));
                chk(oc[i] === (m_left[i] != 0), "ocupado", i, int'(oc[i]), int'(m_left[i] != 0));
`ifdef DECOD_ERRO_EN
                chk(er[i] === m_err[i], "erro", i, int'(er[i]), int'(m_err[i]));
`endif
                if (prev_kp[i] == 10'd0 && kp[i] != 10'd0) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        chk(1'b0, "unexpected_press", i, int'(kp[i]), 0);
                    end else begin
                        d = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk(kp[i] === (10'(1) << d), "press_digit", i, int'(kp[i]), 1 << d);
                    end
                end
                prev_kp[i] <= kp[i];
            end
        end
    end

    // Holds a digit valid until dut0 takes it; pronto is stable at the negedge before the capturing edge.
    task automatic send(input int d);
        bit acc;
        int n;
        valido = 1'b1;
        BCD    = 4'(d);
        acc    = 1'b0;
        n      = 0;
        while (!acc && n < 50) begin
            acc = pr[0] && !enablen;
            @(negedge clk);
            n++;
        end
        if (!acc) chk(1'b0, "send_timeout", 0, n, 50);
        valido = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        // single digit
        send(7);
        idle(10);
        // back-to-back with valido held
        send(0);
        send(9);
        idle(10);
        // blocked by enablen
        enablen = 1'b1;
        valido  = 1'b1;
        BCD     = 4'd3;
        idle(10);
        enablen = 1'b0;
        send(3);
        idle(10);
        // invalid code
        send(12);
        idle(4);
        // reset in the second press cycle
        send(5);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        send(1);
        idle(10);
        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            valido  = ($urandom_range(0, 9) < 7);
            BCD     = 4'($urandom_range(0, 15));
            enablen = ($urandom_range(0, 9) < 2);
            reset   = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end
        valido  = 1'b0;
        enablen = 1'b0;
        reset   = 1'b0;
        idle(20);
        chk(q0.size() == 0, "drain0", 0, q0.size(), 0);
        chk(q1.size() == 0, "drain1", 1, q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
